chargen: RTL and testbench



---
 rtl/chargen_pkg.sv | 25 ++
 rtl/chargen.sv | 82 ++++++++
 tb/tb_chargen.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/chargen_pkg.sv
// chargen_pkg: shared definitions for the character generator and its
// downstream UART path.
//   - TRUE/FALSE macros shared with the UART transmitter
//   - ASCII constants CR, LF, SP, TILDE
//   - state_t: generator position within a line (S_CHAR, S_CR, S_LF)
`ifndef CHARGEN_TRUE_FALSE_MACROS
`define CHARGEN_TRUE_FALSE_MACROS
`define TRUE  1'b1
`define FALSE 1'b0
`endif

package chargen_pkg;

    localparam logic [7:0] CR    = 8'h0D;
    localparam logic [7:0] LF    = 8'h0A;
    localparam logic [7:0] SP    = 8'h20;
    localparam logic [7:0] TILDE = 8'h7E;

    typedef enum logic [1:0] {
        S_CHAR,
        S_CR,
        S_LF
    } state_t;

endpackage

// File: rtl/chargen.sv
// chargen: RFC 864-style rotating printable-ASCII line generator.
// Each line is LINE_LEN characters followed by CR LF; each new line starts
// one character later in the FIRST_CHAR..LAST_CHAR rotation.
// Ports:
//   clk      in   rising-edge clock
//   n_rst    in   asynchronous active-low reset
//   enable   in   run request (sampled when no byte is pending or on transfer)
//   data     out  byte offered downstream (registered)
//   valid_n  out  active-low: data is valid while low (registered)
//   ready_n  in   active-low: downstream can take a byte while low
module chargen
    import chargen_pkg::*;
#(
    parameter int unsigned LINE_LEN   = 72,
    parameter logic [7:0]  FIRST_CHAR = SP,
    parameter logic [7:0]  LAST_CHAR  = TILDE
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       enable,
    output logic [7:0] data,
    output logic       valid_n,
    input  logic       ready_n
);

    localparam logic [6:0] LAST_COL = 7'(LINE_LEN - 1);

    // state/cur/col/line_start describe the NEXT byte to present, so that
    // dropping enable freezes the position and re-enable resumes there.
    state_t     state;
    logic [7:0] cur;
    logic [7:0] line_start;
    logic [6:0] col;

    function automatic logic [7:0] wrap_inc(input logic [7:0] c);
        return (c == LAST_CHAR) ? FIRST_CHAR : c + 8'd1;
    endfunction

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state      <= S_CHAR;
            cur        <= FIRST_CHAR;
            line_start <= FIRST_CHAR;
            col        <= '0;
            data       <= FIRST_CHAR;
            valid_n    <= `TRUE;
        end else if (valid_n == `TRUE || ready_n == `FALSE) begin
            // Slot is free: either nothing pending or the pending byte
            // transfers on this edge.
            if (enable) begin
                valid_n <= `FALSE;
                case (state)
                    S_CHAR: begin
                        data <= cur;
                        cur  <= wrap_inc(cur);
                        col  <= col + 7'd1;
                        if (col == LAST_COL) begin
                            state <= S_CR;
                        end
                    end
                    S_CR: begin
                        data  <= CR;
                        state <= S_LF;
                    end
                    S_LF: begin
                        data       <= LF;
                        line_start <= wrap_inc(line_start);
                        cur        <= wrap_inc(line_start);
                        col        <= '0;
                        state      <= S_CHAR;
                    end
                    default: begin
                        state <= S_CHAR;
                    end
                endcase
            end else begin
                valid_n <= `TRUE;
            end
        end
    end

endmodule

// File: tb/tb_chargen.sv
// tb_chargen: randomized scoreboard bench for chargen. Expected bytes come
// from a stream-index model (line = n / (L+2), position = n % (L+2)).
module tb_chargen;

    localparam int unsigned L     = 72;
    localparam int unsigned PER   = L + 2;
    localparam int unsigned NCHAR = 95;

    logic       clk = 1'b0;
    logic       n_rst = 1'b0;
    logic       enable = 1'b0;
    logic       ready_n = 1'b1;
    logic [7:0] data;
    logic       valid_n;

    int unsigned checks = 0;
    int unsigned errors = 0;
    int unsigned model_idx = 0;
    int unsigned xfers = 0;
    logic [7:0]  exp_q[$];

    chargen #(.LINE_LEN(L), .FIRST_CHAR(8'h20), .LAST_CHAR(8'h7E)) dut (
        .clk(clk), .n_rst(n_rst), .enable(enable),
        .data(data), .valid_n(valid_n), .ready_n(ready_n)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] model_byte(input int unsigned n);
        int unsigned line_no = n / PER;
        int unsigned pos = n % PER;
        if (pos < L) return 8'h20 + 8'((line_no + pos) % NCHAR);
        else if (pos == L) return 8'h0D;
        else return 8'h0A;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic topup();
        while (exp_q.size() < 8) begin
            exp_q.push_back(model_byte(model_idx));
            model_idx++;
        end
    endtask

    // Advance one clock; inputs change #1 after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
        if (n_rst) topup();
    endtask

    task automatic do_reset();
        n_rst = 1'b0;
        exp_q.delete();
        model_idx = 0;
        step();
        step();
    endtask

    task automatic release_reset();
        n_rst = 1'b1;
        topup();
    endtask

    task automatic wait_data(input logic [7:0] b, input int unsigned max_cycles);
        int unsigned n = 0;
        while (!(valid_n == 1'b0 && data == b) && n < max_cycles) begin
            step();
            n++;
        end
        check("wait_data_timeout", {24'h0, data}, {24'h0, b});
    endtask

    // Monitor: sample at falling edge; a transfer happens on the next
    // rising edge when both valid_n and ready_n are low.
    logic       prev_hold = 1'b0;
    logic [7:0] prev_data = '0;
    always @(negedge clk) begin
        if (!n_rst) begin
            prev_hold = 1'b0;
        end else begin
            if (prev_hold) begin
                check("hold_valid", {31'h0, valid_n}, 32'h0);
                check("hold_data", {24'h0, data}, {24'h0, prev_data});
            end
            if (valid_n == 1'b0 && ready_n == 1'b0) begin
                xfers++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL scoreboard_empty: got %0h expected none", data);
                end else begin
                    check("stream_byte", {24'h0, data}, {24'h0, exp_q.pop_front()});
                end
            end
            prev_hold = (valid_n == 1'b0 && ready_n == 1'b1);
            prev_data = data;
        end
    end

    initial begin
        int unsigned x0;
        // Reset state with enable high
        enable = 1'b1;
        ready_n = 1'b0;
        do_reset();
        check("reset_valid_n", {31'h0, valid_n}, 32'h1);
        check("reset_data", {24'h0, data}, 32'h20);
        release_reset();
        step();
        check("start_valid_n", {31'h0, valid_n}, 32'h0);
        check("start_data", {24'h0, data}, 32'h20);

        // Back-to-back through a full pattern period and beyond
        x0 = xfers;
        for (int unsigned i = 0; i < 7030 + 80; i++) begin
            step();
            if (valid_n != 1'b0) check("b2b_valid_n", {31'h0, valid_n}, 32'h0);
        end
        check("throughput", xfers - x0, 7030 + 80);

        // Backpressure at column 10
        do_reset();
        release_reset();
        step();
        wait_data(8'h2A, 20);
        ready_n = 1'b1;
        for (int unsigned i = 0; i < 5; i++) begin
            step();
            check("bp_data", {24'h0, data}, 32'h2A);
            check("bp_valid_n", {31'h0, valid_n}, 32'h0);
        end
        ready_n = 1'b0;
        step();
        check("bp_next", {24'h0, data}, 32'h2B);

        // Enable dropped while CR pending
        wait_data(8'h0D, 100);
        enable = 1'b0;
        step();
        check("drop_valid_n", {31'h0, valid_n}, 32'h1);
        step();
        step();
        check("drop_idle_valid_n", {31'h0, valid_n}, 32'h1);
        enable = 1'b1;
        step();
        check("resume_lf", {24'h0, data}, 32'h0A);
        check("resume_valid_n", {31'h0, valid_n}, 32'h0);
        step();
        check("resume_line1", {24'h0, data}, 32'h21);

        // Asynchronous reset mid-line at column 30
        do_reset();
        release_reset();
        step();
        wait_data(8'h3E, 40);
        #2;
        n_rst = 1'b0;
        #1;
        check("async_valid_n", {31'h0, valid_n}, 32'h1);
        check("async_data", {24'h0, data}, 32'h20);
        exp_q.delete();
        model_idx = 0;
        step();
        release_reset();
        step();
        check("restart_data", {24'h0, data}, 32'h20);
        check("restart_valid_n", {31'h0, valid_n}, 32'h0);

        // Randomized enable and backpressure
        for (int unsigned i = 0; i < 3000; i++) begin
            enable = ($urandom_range(0, 5) != 0);
            ready_n = ($urandom_range(0, 2) == 0);
            step();
        end
        ready_n = 1'b1;
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
